kalman_filter_mc: RTL and testbench

Multi-channel successor to the single-cycle 1D Kalman filter (A=1, B=0, H=1). It time-multiplexes NUM_CH independent scalar filters over one shared datapath, with per-channel x/P state and a valid/ready measurement handshake. The wide single-cycle divide is replaced by an iterative divider so the block closes timing. It sits between sensor-sample collection and downstream consumers of the estimates.

---
 rtl/kalman_pkg.sv | 55 +++++
 rtl/kalman_filter_mc_div.sv | 80 ++++++++
 rtl/kalman_filter_mc.sv | 224 ++++++++++++++++++++++
 tb/tb_kalman_filter_mc.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kalman_pkg.sv
// Shared types, derived widths and fixed-point helpers for the multi-channel Kalman filter.
package kalman_pkg;

    localparam int unsigned STATE_BITS = 16;
    localparam int unsigned COV_BITS   = 64;
    localparam int unsigned COV_Q      = 30;
    localparam int unsigned K_Q        = 31;

    localparam int unsigned K_W       = K_Q + 1;
    localparam int unsigned QUO_W     = K_Q + 2;
    localparam int unsigned PM_W      = COV_BITS + 1;
    localparam int unsigned DEN_W     = COV_BITS + 2;
    localparam int unsigned DIV_DEN_W = COV_BITS + 1;
    localparam int unsigned NUM_W     = COV_BITS + K_Q + 1;
    localparam int unsigned INNOV_W   = STATE_BITS + 1;
    localparam int unsigned XPROD_W   = K_W + 1 + INNOV_W;
    localparam int unsigned PPROD_W   = K_W + 1 + PM_W;
    localparam int unsigned WIDE_W    = 128;

    localparam logic [K_W-1:0]      K_ONE = {1'b1, {K_Q{1'b0}}};
    localparam logic [COV_BITS-1:0] P0    = COV_BITS'(1) << COV_Q;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREDICT = 2'd1,
        ST_DIVIDE  = 2'd2,
        ST_UPDATE  = 2'd3
    } kf_state_e;

    typedef logic signed [WIDE_W-1:0] wide_t;

    // Round half away from zero, then arithmetic shift right by s (s >= 1).
    function automatic wide_t rnd_shift(input wide_t v, input int unsigned s);
        wide_t half;
        wide_t adj;
        half = wide_t'(1) <<< (s - 1);
        adj  = v[WIDE_W-1] ? (half - wide_t'(1)) : half;
        return (v + adj) >>> s;
    endfunction

    // Clamp v to the range of a w-bit signed value.
    function automatic wide_t saturate(input wide_t v, input int unsigned w);
        wide_t mx;
        wide_t mn;
        mx = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        mn = ~mx;
        if (v > mx) begin
            return mx;
        end else if (v < mn) begin
            return mn;
        end
        return v;
    endfunction

endpackage

// File: rtl/kalman_filter_mc_div.sv
// Restoring unsigned divider, fixed QUO_W iterations; quotient saturates to all-ones on overflow.
module kf_seq_div
    import kalman_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_W-1:0]     num,
    input  logic [DIV_DEN_W-1:0] den,
    output logic [QUO_W-1:0]     quo,
    output logic                 done_c
);

    localparam int unsigned REM_W = DIV_DEN_W + 1;
    localparam int unsigned CNT_W = $clog2(QUO_W);

    logic [REM_W-1:0]     rem_q, rem_d, trial_c;
    logic [QUO_W-1:0]     lo_q, lo_d, quo_q, quo_d;
    logic [DIV_DEN_W-1:0] den_q, den_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 active_q, active_d, ovf_q, ovf_d;

    assign done_c = active_q && (cnt_q == CNT_W'(QUO_W - 1));
    assign quo    = ovf_q ? '1 : quo_q;

    always_comb begin
        rem_d    = rem_q;
        lo_d     = lo_q;
        quo_d    = quo_q;
        den_d    = den_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        ovf_d    = ovf_q;
        trial_c  = {rem_q[REM_W-2:0], lo_q[QUO_W-1]};
        if (start) begin
            // Upper numerator bits seed the remainder; if they already reach den the quotient cannot fit.
            rem_d    = REM_W'(num[NUM_W-1:QUO_W]);
            lo_d     = num[QUO_W-1:0];
            den_d    = den;
            quo_d    = '0;
            cnt_d    = '0;
            active_d = 1'b1;
            ovf_d    = DIV_DEN_W'(num[NUM_W-1:QUO_W]) >= den;
        end else if (active_q) begin
            lo_d = lo_q << 1;
            if (trial_c >= {1'b0, den_q}) begin
                rem_d = trial_c - {1'b0, den_q};
                quo_d = {quo_q[QUO_W-2:0], 1'b1};
            end else begin
                rem_d = trial_c;
                quo_d = {quo_q[QUO_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (done_c) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q    <= '0;
            lo_q     <= '0;
            quo_q    <= '0;
            den_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            lo_q     <= lo_d;
            quo_q    <= quo_d;
            den_q    <= den_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: rtl/kalman_filter_mc.sv
// Time-multiplexed scalar Kalman filter (A=1, B=0, H=1) over NUM_CH channels.
// Optional innovation gating is enabled by defining KF_INNOV_GATE_EN.
module kalman_filter_mc
    import kalman_pkg::*;
#(
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  z_valid,
    output logic                  z_ready,
    input  logic [CH_W-1:0]       z_ch,
    input  logic [STATE_BITS-1:0] z_in,
    input  logic [COV_BITS-1:0]   Q_var,
    input  logic [COV_BITS-1:0]   R_var,
    input  logic                  init_valid,
    input  logic [CH_W-1:0]       init_ch,
`ifdef KF_INNOV_GATE_EN
    input  logic [STATE_BITS-1:0] gate_thr,
    output logic                  outlier,
`endif
    output logic                  x_valid,
    output logic [CH_W-1:0]       x_ch,
    output logic [STATE_BITS-1:0] x_out,
    output logic [COV_BITS-1:0]   p_out,
    output logic [K_W-1:0]        k_out,
    output logic                  busy
);

    kf_state_e                    state_q, state_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic signed [STATE_BITS-1:0] z_q, z_d;
    logic signed [COV_BITS-1:0]   qv_q, qv_d, rv_q, rv_d;
    logic signed [PM_W-1:0]       pm_q, pm_d;
    logic                         kill_q, kill_d;
    logic signed [STATE_BITS-1:0] x_mem_q [NUM_CH];
    logic signed [STATE_BITS-1:0] x_mem_d [NUM_CH];
    logic signed [COV_BITS-1:0]   p_mem_q [NUM_CH];
    logic signed [COV_BITS-1:0]   p_mem_d [NUM_CH];
    logic                         x_valid_q, x_valid_d;
    logic [CH_W-1:0]              x_ch_q, x_ch_d;
    logic [STATE_BITS-1:0]        x_out_q, x_out_d;
    logic [COV_BITS-1:0]          p_out_q, p_out_d;
    logic [K_W-1:0]               k_out_q, k_out_d;

    logic                         accept_c, init_hit_c, reject_c, div_done_c;
    logic signed [PM_W-1:0]       pm_c;
    logic signed [DEN_W-1:0]      den_c;
    logic [NUM_W-1:0]             div_num_c;
    logic [DIV_DEN_W-1:0]         div_den_c;
    logic [QUO_W-1:0]             div_quo;
    logic [K_W-1:0]               k_c;
    logic signed [INNOV_W-1:0]    innov_c;
    logic [INNOV_W-1:0]           abs_innov_c;
    logic signed [XPROD_W-1:0]    xprod_c;
    logic signed [PPROD_W-1:0]    pprod_c;
    logic signed [STATE_BITS-1:0] x_upd_c;
    logic signed [COV_BITS-1:0]   p_upd_c;

    assign z_ready    = (state_q == ST_IDLE) && !init_valid;
    assign busy       = (state_q != ST_IDLE);
    assign accept_c   = z_valid && z_ready;
    assign init_hit_c = init_valid && (init_ch == ch_q) && (state_q != ST_IDLE);
    assign x_valid    = x_valid_q;
    assign x_ch       = x_ch_q;
    assign x_out      = x_out_q;
    assign p_out      = p_out_q;
    assign k_out      = k_out_q;

    kf_seq_div u_div (
        .clk    (clk),
        .reset  (reset),
        .start  (state_q == ST_PREDICT),
        .num    (div_num_c),
        .den    (div_den_c),
        .quo    (div_quo),
        .done_c (div_done_c)
    );

    // Predict terms, gain clamp and update arithmetic for the in-flight channel.
    always_comb begin
        pm_c        = PM_W'(p_mem_q[ch_q]) + PM_W'(qv_q);
        den_c       = DEN_W'(pm_c) + DEN_W'(rv_q);
        div_den_c   = (den_c[DEN_W-1] || (den_c == '0)) ? DIV_DEN_W'(1) : DIV_DEN_W'(den_c);
        div_num_c   = pm_c[PM_W-1] ? '0 : {pm_c, {K_Q{1'b0}}};
        k_c         = (div_quo > QUO_W'(K_ONE)) ? K_ONE : div_quo[K_W-1:0];
        innov_c     = INNOV_W'(z_q) - INNOV_W'(x_mem_q[ch_q]);
        abs_innov_c = innov_c[INNOV_W-1] ? -innov_c : innov_c;
        xprod_c     = XPROD_W'($signed({1'b0, k_c})) * XPROD_W'(innov_c);
        pprod_c     = PPROD_W'($signed({1'b0, K_ONE - k_c})) * PPROD_W'(pm_q);
        x_upd_c     = STATE_BITS'(saturate(rnd_shift(WIDE_W'(xprod_c), K_Q)
                                           + WIDE_W'(x_mem_q[ch_q]), STATE_BITS));
        p_upd_c     = COV_BITS'(saturate(rnd_shift(WIDE_W'(pprod_c), K_Q), COV_BITS));
        reject_c    = 1'b0;
`ifdef KF_INNOV_GATE_EN
        reject_c    = abs_innov_c > INNOV_W'(gate_thr);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept_c && (32'(z_ch) < NUM_CH)) state_d = ST_PREDICT;
            ST_PREDICT: state_d = ST_DIVIDE;
            ST_DIVIDE:  if (div_done_c) state_d = ST_UPDATE;
            ST_UPDATE:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

`ifdef KF_INNOV_GATE_EN
    logic outlier_q, outlier_d;
    assign outlier = outlier_q;
`endif

    always_comb begin
        ch_d      = ch_q;
        z_d       = z_q;
        qv_d      = qv_q;
        rv_d      = rv_q;
        pm_d      = pm_q;
        kill_d    = kill_q;
        x_mem_d   = x_mem_q;
        p_mem_d   = p_mem_q;
        x_valid_d = 1'b0;
        x_ch_d    = x_ch_q;
        x_out_d   = x_out_q;
        p_out_d   = p_out_q;
        k_out_d   = k_out_q;
`ifdef KF_INNOV_GATE_EN
        outlier_d = outlier_q;
`endif
        if ((state_q == ST_IDLE) && accept_c) begin
            ch_d   = z_ch;
            z_d    = z_in;
            qv_d   = Q_var;
            rv_d   = R_var;
            kill_d = 1'b0;
        end
        if (init_hit_c) begin
            kill_d = 1'b1;
        end
        if (state_q == ST_PREDICT) begin
            pm_d = pm_c;
        end
        if ((state_q == ST_UPDATE) && !kill_q && !init_hit_c) begin
            x_valid_d = 1'b1;
            x_ch_d    = ch_q;
            if (reject_c) begin
                x_out_d = x_mem_q[ch_q];
                p_out_d = COV_BITS'(saturate(WIDE_W'(pm_q), COV_BITS));
                k_out_d = '0;
            end else begin
                x_out_d = x_upd_c;
                p_out_d = p_upd_c;
                k_out_d = k_c;
            end
            x_mem_d[ch_q] = x_out_d;
            p_mem_d[ch_q] = p_out_d;
`ifdef KF_INNOV_GATE_EN
            outlier_d = reject_c;
`endif
        end
        // Re-init lands after any writeback so it always wins.
        if (init_valid && (32'(init_ch) < NUM_CH)) begin
            x_mem_d[init_ch] = '0;
            p_mem_d[init_ch] = P0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q      <= '0;
            z_q       <= '0;
            qv_q      <= '0;
            rv_q      <= '0;
            pm_q      <= '0;
            kill_q    <= 1'b0;
            x_valid_q <= 1'b0;
            x_ch_q    <= '0;
            x_out_q   <= '0;
            p_out_q   <= '0;
            k_out_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                x_mem_q[i] <= '0;
                p_mem_q[i] <= P0;
            end
        end else begin
            ch_q      <= ch_d;
            z_q       <= z_d;
            qv_q      <= qv_d;
            rv_q      <= rv_d;
            pm_q      <= pm_d;
            kill_q    <= kill_d;
            x_valid_q <= x_valid_d;
            x_ch_q    <= x_ch_d;
            x_out_q   <= x_out_d;
            p_out_q   <= p_out_d;
            k_out_q   <= k_out_d;
            x_mem_q   <= x_mem_d;
            p_mem_q   <= p_mem_d;
        end
    end

`ifdef KF_INNOV_GATE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            outlier_q <= 1'b0;
        end else begin
            outlier_q <= outlier_d;
        end
    end
`endif

endmodule

// File: tb/tb_kalman_filter_mc.sv
// Directed bench for kalman_filter_mc with hand-computed expected estimates.
module tb_kalman_filter_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        z_valid;
    logic        z_ready;
    logic [1:0]  z_ch;
    logic [15:0] z_in;
    logic [63:0] Q_var;
    logic [63:0] R_var;
    logic        init_valid;
    logic [1:0]  init_ch;
    logic        x_valid;
    logic [1:0]  x_ch;
    logic [15:0] x_out;
    logic [63:0] p_out;
    logic [31:0] k_out;
    logic        busy;
`ifdef KF_INNOV_GATE_EN
    logic [15:0] gate_thr;
    logic        outlier;
`endif

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] TWO30 = 64'd1073741824;
    localparam logic [63:0] TWO29 = 64'd536870912;
    localparam logic [31:0] K_HALF = 32'd1073741824;
    localparam logic [31:0] K_FULL = 32'd2147483648;

    kalman_filter_mc #(.NUM_CH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .z_valid    (z_valid),
        .z_ready    (z_ready),
        .z_ch       (z_ch),
        .z_in       (z_in),
        .Q_var      (Q_var),
        .R_var      (R_var),
        .init_valid (init_valid),
        .init_ch    (init_ch),
`ifdef KF_INNOV_GATE_EN
        .gate_thr   (gate_thr),
        .outlier    (outlier),
`endif
        .x_valid    (x_valid),
        .x_ch       (x_ch),
        .x_out      (x_out),
        .p_out      (p_out),
        .k_out      (k_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Offer one measurement from IDLE and wait (bounded) for its estimate.
    task automatic do_update(input logic [1:0] ch, input logic [15:0] z,
                             input logic [63:0] q, input logic [63:0] r, output int lat);
        z_valid = 1'b1; z_ch = ch; z_in = z; Q_var = q; R_var = r;
        @(posedge clk); #1;
        z_valid = 1'b0;
        lat = 0;
        while (x_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (x_valid !== 1'b0) begin n_err++; $display("FAIL rst_x_valid: got %0d want 0", x_valid); end
        n_cmp++; if (x_out !== 16'h0) begin n_err++; $display("FAIL rst_x_out: got %h want 0", x_out); end
        n_cmp++; if (p_out !== 64'h0) begin n_err++; $display("FAIL rst_p_out: got %0d want 0", p_out); end
        n_cmp++; if (k_out !== 32'h0) begin n_err++; $display("FAIL rst_k_out: got %0d want 0", k_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0d want 0", busy); end
        reset = 1'b0;
        #1;
        n_cmp++; if (z_ready !== 1'b1) begin n_err++; $display("FAIL rst_z_ready: got %0d want 1", z_ready); end
    endtask

    task automatic test_basic();
        int lat;
        do_update(2'd0, 16'h4000, 64'd0, TWO30, lat);
        n_cmp++; if (lat != 35) begin n_err++; $display("FAIL b1_latency: got %0d want 35", lat); end
        n_cmp++; if (k_out !== K_HALF) begin n_err++; $display("FAIL b1_k: got %0d want %0d", k_out, K_HALF); end
        n_cmp++; if (x_out !== 16'h2000) begin n_err++; $display("FAIL b1_x: got %h want 2000", x_out); end
        n_cmp++; if (p_out !== TWO29) begin n_err++; $display("FAIL b1_p: got %0d want %0d", p_out, TWO29); end
        n_cmp++; if (x_ch !== 2'd0) begin n_err++; $display("FAIL b1_ch: got %0d want 0", x_ch); end
        n_cmp++; if (z_ready !== 1'b1) begin n_err++; $display("FAIL b1_ready_with_valid: got %0d want 1", z_ready); end
        @(posedge clk); #1;
        n_cmp++; if (x_valid !== 1'b0) begin n_err++; $display("FAIL b1_pulse: got %0d want 0", x_valid); end
        n_cmp++; if (x_out !== 16'h2000) begin n_err++; $display("FAIL b1_hold: got %h want 2000", x_out); end
        do_update(2'd0, 16'h4000, 64'd0, TWO30, lat);
        n_cmp++; if (k_out !== 32'd715827882) begin n_err++; $display("FAIL b2_k: got %0d want 715827882", k_out); end
        n_cmp++; if (x_out !== 16'd10923) begin n_err++; $display("FAIL b2_x: got %0d want 10923", x_out); end
        n_cmp++; if (p_out !== 64'd357913942) begin n_err++; $display("FAIL b2_p: got %0d want 357913942", p_out); end
    endtask

    task automatic test_channels();
        int lat;
        do_update(2'd1, 16'h7FFF, 64'd0, 64'd0, lat);
        n_cmp++; if (k_out !== K_FULL) begin n_err++; $display("FAIL c1_k: got %0d want %0d", k_out, K_FULL); end
        n_cmp++; if (x_out !== 16'h7FFF) begin n_err++; $display("FAIL c1_x: got %h want 7fff", x_out); end
        n_cmp++; if (p_out !== 64'd0) begin n_err++; $display("FAIL c1_p: got %0d want 0", p_out); end
        n_cmp++; if (x_ch !== 2'd1) begin n_err++; $display("FAIL c1_ch: got %0d want 1", x_ch); end
        // ch0 carries x=10923, P=357913942; R=P gives K=0.5 exactly.
        do_update(2'd0, 16'd12923, 64'd0, 64'd357913942, lat);
        n_cmp++; if (k_out !== K_HALF) begin n_err++; $display("FAIL c0_k: got %0d want %0d", k_out, K_HALF); end
        n_cmp++; if (x_out !== 16'd11923) begin n_err++; $display("FAIL c0_x: got %0d want 11923", x_out); end
        n_cmp++; if (p_out !== 64'd178956971) begin n_err++; $display("FAIL c0_p: got %0d want 178956971", p_out); end
        do_update(2'd2, 16'h1234, 64'hFFFF_FFFF_C000_0000, 64'd0, lat);
        n_cmp++; if (k_out !== 32'd0) begin n_err++; $display("FAIL c2_k: got %0d want 0", k_out); end
        n_cmp++; if (x_out !== 16'd0) begin n_err++; $display("FAIL c2_x: got %h want 0", x_out); end
        n_cmp++; if (p_out !== 64'd0) begin n_err++; $display("FAIL c2_p: got %0d want 0", p_out); end
    endtask

    task automatic test_init_priority();
        int lat;
        z_valid = 1'b1; z_ch = 2'd0; z_in = 16'h0100; Q_var = 64'd0; R_var = TWO30;
        init_valid = 1'b1; init_ch = 2'd2;
        #1;
        n_cmp++; if (z_ready !== 1'b0) begin n_err++; $display("FAIL ip_ready: got %0d want 0", z_ready); end
        @(posedge clk); #1;
        z_valid = 1'b0; init_valid = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ip_busy: got %0d want 0", busy); end
        do_update(2'd2, 16'h4000, 64'd0, TWO30, lat);
        n_cmp++; if (x_out !== 16'h2000) begin n_err++; $display("FAIL ip_x: got %h want 2000", x_out); end
        n_cmp++; if (p_out !== TWO29) begin n_err++; $display("FAIL ip_p: got %0d want %0d", p_out, TWO29); end
    endtask

    task automatic test_init_abort();
        int lat;
        int seen;
        z_valid = 1'b1; z_ch = 2'd3; z_in = 16'h4000; Q_var = 64'd0; R_var = TWO30;
        @(posedge clk); #1;
        z_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        init_valid = 1'b1; init_ch = 2'd3;
        @(posedge clk); #1;
        init_valid = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (x_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL ia_suppressed: got %0d pulses want 0", seen); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ia_idle: got %0d want 0", busy); end
        do_update(2'd3, 16'h4000, 64'd0, TWO30, lat);
        n_cmp++; if (k_out !== K_HALF) begin n_err++; $display("FAIL ia_k: got %0d want %0d", k_out, K_HALF); end
        n_cmp++; if (x_out !== 16'h2000) begin n_err++; $display("FAIL ia_x: got %h want 2000", x_out); end
        n_cmp++; if (p_out !== TWO29) begin n_err++; $display("FAIL ia_p: got %0d want %0d", p_out, TWO29); end
    endtask

    task automatic test_back_to_back();
        int lat;
        z_valid = 1'b1; z_ch = 2'd0; z_in = 16'd100; Q_var = 64'd0; R_var = 64'd0;
        @(posedge clk); #1;
        z_ch = 2'd3; z_in = 16'hFF9C;
        n_cmp++; if (z_ready !== 1'b0) begin n_err++; $display("FAIL bb_ready_busy: got %0d want 0", z_ready); end
        lat = 0;
        while (x_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat != 35) begin n_err++; $display("FAIL bb1_latency: got %0d want 35", lat); end
        n_cmp++; if (x_out !== 16'd100) begin n_err++; $display("FAIL bb1_x: got %0d want 100", x_out); end
        n_cmp++; if (k_out !== K_FULL) begin n_err++; $display("FAIL bb1_k: got %0d want %0d", k_out, K_FULL); end
        n_cmp++; if (z_ready !== 1'b1) begin n_err++; $display("FAIL bb1_ready: got %0d want 1", z_ready); end
        @(posedge clk); #1;
        z_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bb2_accepted: got %0d want 1", busy); end
        lat = 0;
        while (x_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat != 35) begin n_err++; $display("FAIL bb2_latency: got %0d want 35", lat); end
        n_cmp++; if (x_out !== 16'hFF9C) begin n_err++; $display("FAIL bb2_x: got %h want ff9c", x_out); end
        n_cmp++; if (x_ch !== 2'd3) begin n_err++; $display("FAIL bb2_ch: got %0d want 3", x_ch); end
        n_cmp++; if (p_out !== 64'd0) begin n_err++; $display("FAIL bb2_p: got %0d want 0", p_out); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        z_valid = 1'b1; z_ch = 2'd1; z_in = 16'h4000; Q_var = 64'd0; R_var = TWO30;
        @(posedge clk); #1;
        z_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %0d want 0", busy); end
        n_cmp++; if (x_out !== 16'h0) begin n_err++; $display("FAIL rm_x_out: got %h want 0", x_out); end
        n_cmp++; if (p_out !== 64'h0) begin n_err++; $display("FAIL rm_p_out: got %0d want 0", p_out); end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (x_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rm_no_valid: got %0d pulses want 0", seen); end
        do_update(2'd1, 16'h4000, 64'd0, TWO30, lat);
        n_cmp++; if (x_out !== 16'h2000) begin n_err++; $display("FAIL rm_x: got %h want 2000", x_out); end
        n_cmp++; if (p_out !== TWO29) begin n_err++; $display("FAIL rm_p: got %0d want %0d", p_out, TWO29); end
    endtask

`ifdef KF_INNOV_GATE_EN
    task automatic test_gate();
        int lat;
        gate_thr = 16'h1000;
        do_update(2'd2, 16'h4000, 64'd1048576, TWO30, lat);
        n_cmp++; if (outlier !== 1'b1) begin n_err++; $display("FAIL g_outlier: got %0d want 1", outlier); end
        n_cmp++; if (x_out !== 16'h0) begin n_err++; $display("FAIL g_x: got %h want 0", x_out); end
        n_cmp++; if (p_out !== 64'd1074790400) begin n_err++; $display("FAIL g_p: got %0d want 1074790400", p_out); end
        n_cmp++; if (k_out !== 32'd0) begin n_err++; $display("FAIL g_k: got %0d want 0", k_out); end
        n_cmp++; if (lat != 35) begin n_err++; $display("FAIL g_latency: got %0d want 35", lat); end
        gate_thr = 16'hFFFF;
        do_update(2'd0, 16'h4000, 64'd0, TWO30, lat);
        n_cmp++; if (outlier !== 1'b0) begin n_err++; $display("FAIL g_pass_outlier: got %0d want 0", outlier); end
        n_cmp++; if (x_out !== 16'h2000) begin n_err++; $display("FAIL g_pass_x: got %h want 2000", x_out); end
    endtask
`endif

    initial begin
        reset = 1'b1; z_valid = 1'b0; z_ch = '0; z_in = '0; Q_var = '0; R_var = '0;
        init_valid = 1'b0; init_ch = '0;
`ifdef KF_INNOV_GATE_EN
        gate_thr = 16'hFFFF;
`endif
        test_reset();
        test_basic();
        test_channels();
        test_init_priority();
        test_init_abort();
        test_back_to_back();
        test_reset_mid();
`ifdef KF_INNOV_GATE_EN
        test_gate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
